// File: rtl/uart_apb_sequencer_if.sv
// APB bus bundle between uart_apb_sequencer (master) and the uart_16550
// APB slave port.
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE : driven by the master
//   PRDATA/PREADY/PSLVERR            : driven by the slave
interface uart_apb_sequencer_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/uart_apb_sequencer.sv
// APB master that configures a uart_16550 (divisor, FCR, LCR) and then
// arbitrates all register traffic: LSR polls, THR writes fed from a byte
// stream and RBR reads delivered to a byte stream.
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   apb                      APB master port (uart_apb_sequencer_if.master)
//   cfg_start/divisor/lcr    configuration request (pulse, sampled values)
//   cfg_done, err            running flag, sticky PSLVERR flag
//   tx_data/valid/ready      transmit byte stream (tx_ready is a 1-cycle strobe)
//   rx_data/valid/ready      receive byte stream, rx_status = {BI, FE, PE}
module uart_apb_sequencer #(
  parameter logic [31:0] ADDR_BASE  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  uart_apb_sequencer_if.master        apb,
  input  logic                        cfg_start,
  input  logic [15:0]                 cfg_divisor,
  input  logic [7:0]                  cfg_lcr,
  output logic                        cfg_done,
  output logic                        err,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [2:0]                  rx_status
);

  localparam logic [7:0] OFF_DATA = 8'h00;
  localparam logic [7:0] OFF_FCR  = 8'h08;
  localparam logic [7:0] OFF_LCR  = 8'h0C;
  localparam logic [7:0] OFF_LSR  = 8'h14;
  localparam logic [7:0] OFF_DIV1 = 8'h1C;
  localparam logic [7:0] OFF_DIV2 = 8'h20;

  typedef enum logic [2:0] {
    IDLE, CFG_DIV1, CFG_DIV2, CFG_FCR, CFG_LCR, POLL, TX, RX
  } state_t;

  state_t     state;
  state_t     poll_nxt;
  logic [4:0] credits;
  logic [4:0] credits_upd;
  logic       prio_tx;
  logic [7:0] div_hi_q;
  logic [7:0] lcr_q;
  logic [2:0] lsr_err_q;
  logic       xfer_done;
  logic       in_cfg;
  logic       rx_pend;
  logic       tx_pend;
  logic       unused_prdata;

  assign unused_prdata = ^apb.PRDATA[31:8];

  assign xfer_done = apb.PSEL & apb.PENABLE & apb.PREADY;
  assign in_cfg    = (state == CFG_DIV1) || (state == CFG_DIV2) ||
                     (state == CFG_FCR)  || (state == CFG_LCR);

  function automatic logic [31:0] reg_addr(input logic [7:0] off);
    return ADDR_BASE | {24'h0, off};
  endfunction

  // POLL decision, evaluated against the LSR value arriving on PRDATA;
  // a THRE refresh of the credits counts toward this same decision.
  always_comb begin
    credits_upd = credits;
    if (apb.PRDATA[5]) credits_upd = 5'(FIFO_DEPTH);
    rx_pend  = apb.PRDATA[0] & ~rx_valid;
    tx_pend  = tx_valid & (credits_upd != '0);
    poll_nxt = POLL;
    if (!apb.PSLVERR) begin
      if (rx_pend && tx_pend) poll_nxt = prio_tx ? TX : RX;
      else if (tx_pend)       poll_nxt = TX;
      else if (rx_pend)       poll_nxt = RX;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      cfg_done    <= 1'b0;
      err         <= 1'b0;
      tx_ready    <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_status   <= '0;
      credits     <= '0;
      prio_tx     <= 1'b1;
      div_hi_q    <= '0;
      lcr_q       <= '0;
      lsr_err_q   <= '0;
    end else begin
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (apb.PSEL && !apb.PENABLE) apb.PENABLE <= 1'b1;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            err         <= 1'b0;
            div_hi_q    <= cfg_divisor[15:8];
            lcr_q       <= cfg_lcr;
            prio_tx     <= 1'b1;
            state       <= CFG_DIV1;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b1;
            apb.PADDR   <= reg_addr(OFF_DIV1);
            apb.PWDATA  <= {24'h0, cfg_divisor[7:0]};
          end
        end
        default: begin
          if (xfer_done) begin
            // Every branch below either sets up the next transfer
            // (PSEL stays high, PENABLE drops) or releases the bus.
            apb.PENABLE <= 1'b0;
            if (apb.PSLVERR) err <= 1'b1;
            if (apb.PSLVERR && in_cfg) begin
              state      <= IDLE;
              apb.PSEL   <= 1'b0;
              apb.PWRITE <= 1'b0;
            end else begin
              case (state)
                CFG_DIV1: begin
                  state      <= CFG_DIV2;
                  apb.PADDR  <= reg_addr(OFF_DIV2);
                  apb.PWDATA <= {24'h0, div_hi_q};
                end
                CFG_DIV2: begin
                  state      <= CFG_FCR;
                  apb.PADDR  <= reg_addr(OFF_FCR);
                  apb.PWDATA <= 32'h7;
                end
                CFG_FCR: begin
                  state      <= CFG_LCR;
                  apb.PADDR  <= reg_addr(OFF_LCR);
                  apb.PWDATA <= {24'h0, lcr_q};
                end
                CFG_LCR: begin
                  state      <= POLL;
                  credits    <= 5'(FIFO_DEPTH);
                  cfg_done   <= 1'b1;
                  apb.PADDR  <= reg_addr(OFF_LSR);
                  apb.PWRITE <= 1'b0;
                  apb.PWDATA <= '0;
                end
                POLL: begin
                  if (!apb.PSLVERR) begin
                    credits   <= credits_upd;
                    lsr_err_q <= apb.PRDATA[4:2];
                  end
                  state <= poll_nxt;
                  case (poll_nxt)
                    TX: begin
                      tx_ready   <= 1'b1;
                      prio_tx    <= ~prio_tx;
                      apb.PADDR  <= reg_addr(OFF_DATA);
                      apb.PWRITE <= 1'b1;
                      apb.PWDATA <= {24'h0, tx_data};
                    end
                    RX: begin
                      prio_tx    <= ~prio_tx;
                      apb.PADDR  <= reg_addr(OFF_DATA);
                      apb.PWRITE <= 1'b0;
                      apb.PWDATA <= '0;
                    end
                    default: begin
                      apb.PADDR  <= reg_addr(OFF_LSR);
                      apb.PWRITE <= 1'b0;
                      apb.PWDATA <= '0;
                    end
                  endcase
                end
                TX, RX: begin
                  if (state == TX) begin
                    credits <= (credits != '0) ? credits - 5'd1 : '0;
                  end else if (!apb.PSLVERR) begin
                    rx_data   <= apb.PRDATA[7:0];
                    rx_status <= lsr_err_q;
                    rx_valid  <= 1'b1;
                  end
                  state      <= POLL;
                  apb.PADDR  <= reg_addr(OFF_LSR);
                  apb.PWRITE <= 1'b0;
                  apb.PWDATA <= '0;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer with a behavioural uart_16550 APB
// slave (programmable wait states, PSLVERR on DIV2, scripted LSR/RBR).
module tb_uart_apb_sequencer;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_divisor = '0;
  logic [7:0]  cfg_lcr = '0;
  logic        cfg_done, err;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [2:0]  rx_status;

  uart_apb_sequencer_if apb ();

  uart_apb_sequencer #(.ADDR_BASE(BASE), .FIFO_DEPTH(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(apb.master),
    .cfg_start(cfg_start), .cfg_divisor(cfg_divisor), .cfg_lcr(cfg_lcr),
    .cfg_done(cfg_done), .err(err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_status(rx_status)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- slave model / scoreboard state ----------------
  logic [7:0]  lsr_base = '0;
  logic [7:0]  rbr_val = '0;
  logic [7:0]  lsr_now;
  int          thre_until = 0;
  int unsigned wait_req = 0;
  int unsigned wait_left = 0;
  logic        err_div2 = 1'b0;

  logic [31:0] log_addr  [0:4095];
  logic [31:0] log_wdata [0:4095];
  logic        log_write [0:4095];
  int          log_n = 0;
  int          lsr_rd = 0;
  int          thr_cnt = 0;
  int          rbr_cnt = 0;
  int          cfg_wr = 0;
  logic [7:0]  thr_log [0:63];

  logic [7:0]  tx_mem [0:63];
  int          tx_total = 0;
  int          tx_idx = 0;
  logic [7:0]  rxa_data [0:7];
  logic [2:0]  rxa_stat [0:7];
  int          rxa_n = 0;

  int errors = 0;
  int checks = 0;

  assign lsr_now     = lsr_base | ((lsr_rd < thre_until) ? 8'h20 : 8'h00);
  assign apb.PREADY  = (wait_left == 0);
  assign apb.PSLVERR = err_div2 && apb.PENABLE && (apb.PADDR[7:0] == 8'h20);
  assign tx_valid    = (tx_idx < tx_total);
  assign tx_data     = tx_mem[tx_idx[5:0]];

  always_comb begin
    apb.PRDATA = '0;
    if (apb.PADDR[7:0] == 8'h14)      apb.PRDATA = {24'h0, lsr_now};
    else if (apb.PADDR[7:0] == 8'h00) apb.PRDATA = {24'h0, rbr_val};
  end

  always @(posedge PCLK) begin
    if (apb.PSEL && !apb.PENABLE) wait_left <= wait_req;
    else if (apb.PSEL && apb.PENABLE && wait_left != 0) wait_left <= wait_left - 1;
    if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
      if (log_n < 4096) begin
        log_addr[log_n]  <= apb.PADDR;
        log_wdata[log_n] <= apb.PWDATA;
        log_write[log_n] <= apb.PWRITE;
        log_n <= log_n + 1;
      end
      if (apb.PADDR[7:0] == 8'h14) lsr_rd <= lsr_rd + 1;
      if (apb.PADDR[7:0] == 8'h00 && apb.PWRITE) begin
        if (thr_cnt < 64) thr_log[thr_cnt] <= apb.PWDATA[7:0];
        thr_cnt <= thr_cnt + 1;
      end
      if (apb.PADDR[7:0] == 8'h00 && !apb.PWRITE) rbr_cnt <= rbr_cnt + 1;
      if (apb.PWRITE && (apb.PADDR[7:0] inside {8'h1C, 8'h20, 8'h08, 8'h0C}))
        cfg_wr <= cfg_wr + 1;
    end
    if (tx_valid && tx_ready) tx_idx <= tx_idx + 1;
    if (rx_valid && rx_ready && rxa_n < 8) begin
      rxa_data[rxa_n] <= rx_data;
      rxa_stat[rxa_n] <= rx_status;
      rxa_n <= rxa_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_cfg(input logic [15:0] d, input logic [7:0] l);
    @(negedge PCLK);
    cfg_divisor = d;
    cfg_lcr     = l;
    cfg_start   = 1'b1;
    @(negedge PCLK);
    cfg_start   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, s, snap, snap2;
    logic [31:0] exp_addr [0:3];
    logic [31:0] exp_data [0:3];
    exp_addr[0] = BASE | 32'h1C; exp_data[0] = 32'h36;
    exp_addr[1] = BASE | 32'h20; exp_data[1] = 32'h00;
    exp_addr[2] = BASE | 32'h08; exp_data[2] = 32'h07;
    exp_addr[3] = BASE | 32'h0C; exp_data[3] = 32'h03;
    for (int i = 0; i < 64; i++) tx_mem[i] = 8'(i * 7 + 3);

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst_psel", 32'(apb.PSEL), 0);
    check("rst_penable", 32'(apb.PENABLE), 0);
    check("rst_paddr", apb.PADDR, 0);
    check("rst_cfg_done", 32'(cfg_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    PRESETn = 1'b1;

    // Configuration, zero waits
    st = log_n;
    pulse_cfg(16'h0036, 8'h03);
    repeat (7) @(negedge PCLK);
    check("cfg_done_c8", 32'(cfg_done), 0);
    @(negedge PCLK);
    check("cfg_done_c9", 32'(cfg_done), 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cfg_addr%0d", i), log_addr[st + i], exp_addr[i]);
      check($sformatf("cfg_data%0d", i), log_wdata[st + i], exp_data[i]);
      check($sformatf("cfg_wr%0d", i), 32'(log_write[st + i]), 1);
    end

    // TX credits: 20 bytes, one THRE, then a second THRE
    tx_total   = 20;
    thre_until = lsr_rd + 1;
    for (int i = 0; i < 300 && thr_cnt < 16; i++) @(negedge PCLK);
    snap = lsr_rd;
    repeat (40) @(negedge PCLK);
    check("tx_first_burst", 32'(thr_cnt), 16);
    check("tx_polls_only", 32'(lsr_rd - snap >= 10), 1);
    thre_until = lsr_rd + 1;
    for (int i = 0; i < 300 && thr_cnt < 20; i++) @(negedge PCLK);
    repeat (10) @(negedge PCLK);
    check("tx_total", 32'(thr_cnt), 20);
    check("tx_accepts", 32'(tx_idx), 20);
    for (int i = 0; i < 20; i++)
      check($sformatf("thr_byte%0d", i), 32'(thr_log[i]), 32'(tx_mem[i]));

    // RX with backpressure
    snap    = rbr_cnt;
    rbr_val = 8'hA5;
    lsr_base = 8'h01;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge PCLK);
    check("rx_valid_set", 32'(rx_valid), 1);
    check("rx_data", 32'(rx_data), 32'hA5);
    check("rx_status", 32'(rx_status), 0);
    repeat (30) @(negedge PCLK);
    check("rx_held_one_read", 32'(rbr_cnt - snap), 1);
    check("rx_valid_held", 32'(rx_valid), 1);
    lsr_base = 8'h15;
    rbr_val  = 8'h5A;
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && rxa_n < 2; i++) @(negedge PCLK);
    lsr_base = 8'h00;
    check("rx_acc0_data", 32'(rxa_data[0]), 32'hA5);
    check("rx_acc0_stat", 32'(rxa_stat[0]), 0);
    check("rx_acc1_data", 32'(rxa_data[1]), 32'h5A);
    check("rx_acc1_stat", 32'(rxa_stat[1]), 32'h5);
    repeat (10) @(negedge PCLK);

    // TX/RX alternation with both always pending
    st       = log_n;
    rbr_val  = 8'h77;
    tx_total = 60;
    lsr_base = 8'h21;
    for (int i = 0; i < 200 && log_n < st + 18; i++) @(negedge PCLK);
    s = -1;
    for (int j = st + 2; j < st + 8; j++)
      if (s < 0 && log_addr[j][7:0] == 8'h14) s = j;
    if (s < 0) s = st + 2;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("alt_poll%0d", k), log_addr[s + 2*k], BASE | 32'h14);
      check($sformatf("alt_data%0d", k), log_addr[s + 2*k + 1], BASE);
      check($sformatf("alt_flip%0d", k),
            32'(log_write[s + 2*k + 1] ^ log_write[s + 2*k + 3]), 1);
    end

    // Asynchronous reset during a THR ACCESS
    for (int i = 0; i < 100 && !(apb.PSEL && apb.PENABLE && apb.PWRITE &&
                                 apb.PADDR[7:0] == 8'h00); i++) @(negedge PCLK);
    check("thr_access_found", 32'(apb.PENABLE & apb.PWRITE), 1);
    PRESETn = 1'b0;
    #1;
    check("arst_psel", 32'(apb.PSEL), 0);
    check("arst_penable", 32'(apb.PENABLE), 0);
    check("arst_pwrite", 32'(apb.PWRITE), 0);
    check("arst_paddr", apb.PADDR, 0);
    check("arst_pwdata", apb.PWDATA, 0);
    check("arst_tx_ready", 32'(tx_ready), 0);
    check("arst_rx_valid", 32'(rx_valid), 0);
    check("arst_rx_data", 32'(rx_data), 0);
    check("arst_rx_status", 32'(rx_status), 0);
    check("arst_cfg_done", 32'(cfg_done), 0);
    lsr_base = 8'h00;
    tx_total = tx_idx;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;

    // Wait states on DIV1, PSLVERR on DIV2
    err_div2 = 1'b1;
    wait_req = 3;
    st = log_n;
    pulse_cfg(16'h1234, 8'h1B);
    check("ws_setup_psel", 32'(apb.PSEL & ~apb.PENABLE), 1);
    check("ws_setup_addr", apb.PADDR, BASE | 32'h1C);
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check($sformatf("ws_pen%0d", k), 32'(apb.PENABLE), 1);
      check($sformatf("ws_addr%0d", k), apb.PADDR, BASE | 32'h1C);
      check($sformatf("ws_data%0d", k), apb.PWDATA, 32'h34);
      check($sformatf("ws_ready%0d", k), 32'(apb.PREADY), (k == 3) ? 1 : 0);
    end
    repeat (8) @(negedge PCLK);
    check("slverr_err", 32'(err), 1);
    check("slverr_cfg_done", 32'(cfg_done), 0);
    check("slverr_idle_bus", 32'(apb.PSEL), 0);
    check("slverr_xfers", 32'(log_n - st), 2);
    check("slverr_div2_addr", log_addr[st + 1], BASE | 32'h20);
    check("slverr_div2_data", log_wdata[st + 1], 32'h12);

    // Recovery: accepted cfg_start clears err
    err_div2 = 1'b0;
    wait_req = 0;
    st = log_n;
    pulse_cfg(16'h1234, 8'h1B);
    check("recover_err_clr", 32'(err), 0);
    repeat (10) @(negedge PCLK);
    check("recover_cfg_done", 32'(cfg_done), 1);
    check("recover_div2", log_wdata[st + 1], 32'h12);
    check("recover_lcr", log_wdata[st + 3], 32'h1B);

    // cfg_start outside IDLE is ignored
    snap2 = cfg_wr;
    pulse_cfg(16'hBEEF, 8'h07);
    repeat (20) @(negedge PCLK);
    check("cfg_ignored_writes", 32'(cfg_wr - snap2), 0);
    check("cfg_ignored_done", 32'(cfg_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_apb_sequencer.md
# uart_apb_sequencer

APB master controller for the `uart_16550` APB slave port. It programs the divisor, FIFO control and line control registers from a configuration request. It then schedules all traffic to the UART by polling LSR and interleaving THR writes and RBR reads. Stream-side users see byte-wide valid/ready TX and RX channels and never touch the register map.

## Interface
- `ADDR_BASE`, default 32'h0, base address OR'd into every PADDR.
- `FIFO_DEPTH`, default 16, TX credits granted when LSR.THRE = 1 (range 1..16).
- `PCLK` input 1: clock, rising edge.
- `PRESETn` input 1: asynchronous active-low reset.
- `cfg_start` input 1: 1-cycle pulse; starts configuration; honoured only in IDLE.
- `cfg_divisor` input 16: baud divisor, sampled on `cfg_start`.
- `cfg_lcr` input 8: LCR value, sampled on `cfg_start`.
- `cfg_done` output 1: high while in RUN states.
- `err` output 1: sticky PSLVERR seen; cleared only by reset or an accepted `cfg_start`.
- `tx_data` input 8: byte to transmit.
- `tx_valid` input 1: `tx_data` valid.
- `tx_ready` output 1: 1-cycle accept strobe.
- `rx_data` output 8: received byte.
- `rx_valid` output 1: `rx_data` valid; held until `rx_ready`.
- `rx_ready` input 1: consumer accepts.
- `rx_status` output 3: {BI, FE, PE} from the LSR read that preceded the RBR read. Valid with `rx_valid`.
- `PADDR` output 32, `PWDATA` output 32, `PWRITE` output 1, `PSEL` output 1, `PENABLE` output 1: APB master outputs.
- `PRDATA` input 32, `PREADY` input 1, `PSLVERR` input 1: APB master inputs.

## Operation
- Register offsets (byte):
  - RBR/THR 0x00
  - FCR 0x08
  - LCR 0x0C
  - LSR 0x14
  - DIV1 0x1C (divisor[7:0])
  - DIV2 0x20 (divisor[15:8])
- LSR bits used: [0] DR, [2] PE, [3] FE, [4] BI, [5] THRE.
- States: IDLE, CFG_DIV1, CFG_DIV2, CFG_FCR, CFG_LCR, POLL, TX, RX.
  - Each non-IDLE state performs exactly one APB transfer, then transitions.
- IDLE → CFG_DIV1 on `cfg_start`.
- The CFG chain writes, in order: DIV1 = divisor[7:0], DIV2 = divisor[15:8], FCR = 0x07 (enable, clear both FIFOs), LCR = `cfg_lcr`.
- After the LCR write: credits = FIFO_DEPTH, then go to POLL.
- POLL reads LSR.
  - On completion: if THRE = 1, credits = FIFO_DEPTH.
  - Latch DR and {BI, FE, PE}.
  - Decide the next state:
    - rx_pend = DR & ~rx_valid (output buffer free).
    - tx_pend = tx_valid & (credits ≠ 0).
    - Both pending: alternate using a 1-bit priority flag (TX first after reset/config); flip the flag after each service.
    - One pending: service it.
    - Neither pending: POLL again.
- TX: `tx_ready` pulses in the decision cycle; `tx_data` is captured into PWDATA[7:0] (upper bits 0). Write THR, credits −1, return to POLL.
- RX: read RBR. On completion, rx_data = PRDATA[7:0], rx_status = latched bits, rx_valid = 1. Return to POLL.
- `rx_valid` clears on `rx_valid & rx_ready`. While it is set, no RBR read is issued (backpressure holds bytes in the UART FIFO).
- Credits are 5-bit and saturate at 0; no decrement below 0.
- PSLVERR on any transfer sets `err`.
  - In CFG states: abort to IDLE, `cfg_done` stays 0.
  - In RUN states: the transfer counts as complete, data is discarded (an RX read does not set `rx_valid`), and the FSM continues.
- `cfg_start` outside IDLE is ignored.

## Timing
- APB SETUP cycle: PSEL = 1, PENABLE = 0. Following ACCESS cycle(s): PENABLE = 1, held until PREADY = 1.
- PADDR, PWDATA and PWRITE are stable from SETUP through the last ACCESS cycle.
- Zero-wait: 2 cycles per transfer. Back-to-back transfers: the next SETUP follows immediately; PSEL may stay high and PENABLE drops for 1 cycle.
- The decision is registered at ACCESS completion. The next SETUP is the following cycle.
- Configuration with zero waits: 8 cycles from the cycle after `cfg_start`. `cfg_done` rises the cycle after the LCR ACCESS completes.
- Best-case TX byte rate: 1 byte per 4 cycles (POLL + TX).
- Reset values: PSEL, PENABLE, PWRITE, tx_ready, rx_valid, cfg_done, err = 0; PADDR, PWDATA, rx_data, rx_status = 0; state IDLE; credits 0; priority flag TX.
- Asynchronous reset mid-transfer: the bus is released immediately (PSEL = 0). The stream byte in flight is lost.

## Test plan
- `cfg_start` with divisor 0x0036, lcr 0x03, zero waits → writes 0x1C=0x36, 0x20=0x00, 0x08=0x07, 0x0C=0x03 in order; `cfg_done` = 1 at cycle 9.
- 20 queued TX bytes; LSR returns 0x20 once, then 0x00 → exactly 16 THR writes, then LSR polls only. Returning 0x20 again → remaining 4 bytes written.
- LSR = 0x01, RBR = 0xA5, `rx_ready` = 0 → `rx_valid` with 0xA5 and no further RBR reads. `rx_ready` = 1 → next RBR read follows the next POLL.
- LSR = 0x21 continuously, `tx_valid` and `rx_ready` always high → TX, RX, TX, RX alternation after each POLL.
- PSLVERR on the DIV2 write → `err` = 1, return to IDLE, `cfg_done` = 0. PREADY low for 3 cycles → PADDR/PWDATA/PENABLE stable over 4 ACCESS cycles.
- PRESETn asserted during a THR ACCESS → all outputs at reset values in the same cycle, `tx_ready` = 0.
